umi_mux: RTL and testbench
==========================

UMI_MUX -- requirements
Module: umi_mux

Interface
REQ-001 SHALL have parameter N, default 4, number of UMI input ports (2..16).
REQ-002 SHALL have parameter AW, default 64, address width.
REQ-003 SHALL have parameter CW, default 32, command width.
REQ-004 SHALL have parameter UW, default 256, payload width.
REQ-005 SHALL have parameter TARGET, default "DEFAULT", implementation target.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port nreset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port umi_in_valid, input, N, per-input valid.
REQ-009 SHALL have port umi_in_cmd, input, N*CW, packed commands; input i occupies [i*CW +: CW].
REQ-010 SHALL have port umi_in_dst_addr, input, N*AW, packed destination addresses.
REQ-011 SHALL have port umi_in_src_addr, input, N*AW, packed source addresses.
REQ-012 SHALL have port umi_in_payload, input, N*UW, packed payloads.
REQ-013 SHALL have port umi_in_ready, output, N, per-input ready.
REQ-014 SHALL have port umi_out_valid, output, 1, merged output valid; feeds the downstream UMI FIFO write side.
REQ-015 SHALL have ports umi_out_cmd/dst_addr/src_addr/payload, output, CW/AW/AW/UW, merged output fields.
REQ-016 SHALL have port umi_out_ready, input, 1, downstream ready (FIFO not full).

Function
REQ-017 SHALL transfer a beat on input i when umi_in_valid[i] & umi_in_ready[i] are both high at a rising clk edge.
REQ-018 SHALL transfer a beat on the output when umi_out_valid & umi_out_ready are both high at a rising clk edge.
REQ-019 SHALL hold the output in one register stage: a beat accepted in cycle t appears on umi_out_* in cycle t+1; latency is exactly 1 cycle.
REQ-020 SHALL define the load condition as load = ~umi_out_valid | umi_out_ready.
REQ-021 SHALL drive umi_in_ready[i] = grant[i] & load, so at most one umi_in_ready bit is high per cycle.
REQ-022 SHALL compute grant by round-robin arbitration over umi_in_valid, starting at priority pointer ptr and searching upward with wrap from N-1 to 0.
REQ-023 SHALL advance ptr to (granted index + 1) mod N only on a cycle with an input transfer; ptr SHALL be unchanged otherwise.
REQ-024 SHALL produce a grant of all zeros, with no register update, when no input is valid.
REQ-025 SHALL, on load with a granted input, capture that input's cmd/dst/src/payload and set umi_out_valid.
REQ-026 SHALL, on load with no granted input, clear umi_out_valid; the data registers MAY hold stale values.
REQ-027 SHALL keep umi_out_* stable while umi_out_valid=1 and umi_out_ready=0.
REQ-028 SHALL sustain one beat per cycle when umi_out_ready is held high: a simultaneous output drain and input capture in the same cycle is allowed.
REQ-029 SHALL NOT require an input to hold valid after a non-transfer cycle; its grant is recomputed every cycle.
REQ-030 SHALL, for N inputs that are continuously valid, grant each input exactly once in every N consecutive transfers.

Reset
REQ-031 SHALL, on nreset low, asynchronously clear umi_out_valid to 0 and ptr to 0.
REQ-032 SHALL hold umi_in_ready at all zeros while in reset.
REQ-033 SHALL discard a beat held in the output register if reset asserts mid-operation; no partial beat is emitted after reset release.
REQ-034 SHALL NOT reset the data registers.

Structure
REQ-035 SHALL take default widths (AW, CW, UW) from the shared umi package constants; this block adds no new typedefs.
REQ-036 SHALL instantiate one sub-module, umi_rrarb (parameter N; inputs clk, nreset, req[N], update; output grant[N]), which holds ptr.
REQ-037 SHALL build the datapath select as a one-hot AND-OR mux on grant; there is no priority encoder on the data path.

Verification
REQ-038 Bench SHALL cover single input: input 2 valid only, cmd=0x11, ready high -> umi_out_cmd=0x11 one cycle later, umi_in_ready=4'b0100.
REQ-039 Bench SHALL cover fairness: all 4 inputs continuously valid, ready high -> output source order 0,1,2,3,0,1 on consecutive cycles.
REQ-040 Bench SHALL cover stall: umi_out_ready=0 for 5 cycles with output valid -> umi_out_* unchanged, umi_in_ready=0; first ready=1 cycle drains and captures the next beat.
REQ-041 Bench SHALL cover wrap: ptr=3 with inputs 0 and 1 valid -> input 0 is granted, then ptr=1.
REQ-042 Bench SHALL cover reset: assert nreset mid-stream with output valid -> umi_out_valid=0 immediately and ptr=0; after release, input 0 wins if all inputs are valid.
REQ-043 Bench SHALL cover sparse input: valid pulses on input 1 on alternating cycles with ready high -> every beat is emitted once, with no duplicates and no losses.

Source files
------------

// File: rtl/umi_mux_pkg.sv
// Shared UMI width constants used as defaults by the UMI mux slice.
package umi_mux_pkg;

  localparam int unsigned UMI_AW = 64;
  localparam int unsigned UMI_CW = 32;
  localparam int unsigned UMI_UW = 256;

endpackage : umi_mux_pkg

// File: rtl/umi_rrarb.sv
// Round-robin arbiter: grants the first requester at or above ptr (with wrap)
// and moves ptr past the winner only when the grant turns into a transfer.
module umi_rrarb
  import umi_mux_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [N-1:0] req,
  input  logic         update,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;
  int unsigned   idx;

  // Search upward from ptr with wrap; remember where ptr goes if this grant transfers.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[PW'(idx)]) begin
        found            = 1'b1;
        grant[PW'(idx)]  = 1'b1;
        ptr_next         = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Priority pointer; only moves on an accepted input beat.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= ptr_next;
    end
  end

endmodule : umi_rrarb

// File: rtl/umi_mux.sv
// N-to-1 UMI merge: round-robin pick among valid inputs into a single
// output register stage that can drain and refill in the same cycle.
module umi_mux
  import umi_mux_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned AW     = UMI_AW,
  parameter int unsigned CW     = UMI_CW,
  parameter int unsigned UW     = UMI_UW,
  parameter              TARGET = "DEFAULT"
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dst_addr,
  input  logic [N*AW-1:0] umi_in_src_addr,
  input  logic [N*UW-1:0] umi_in_payload,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dst_addr,
  output logic [AW-1:0]   umi_out_src_addr,
  output logic [UW-1:0]   umi_out_payload,
  input  logic            umi_out_ready
);

  // Reject unsupported configurations at elaboration.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("umi_mux: N must be in 2..16");
  end
  if (TARGET == "") begin : g_bad_target
    $error("umi_mux: TARGET must not be empty");
  end

  logic [N-1:0]  grant;
  logic          load;
  logic          update;
  logic [CW-1:0] sel_cmd;
  logic [AW-1:0] sel_dst;
  logic [AW-1:0] sel_src;
  logic [UW-1:0] sel_payload;

  // Output stage can take a new beat when empty or being drained this cycle.
  assign load         = ~umi_out_valid | umi_out_ready;
  assign umi_in_ready = grant & {N{load & nreset}};
  assign update       = |(umi_in_valid & umi_in_ready);

  umi_rrarb #(
    .N (N)
  ) u_arb (
    .clk    (clk),
    .nreset (nreset),
    .req    (umi_in_valid),
    .update (update),
    .grant  (grant)
  );

  // One-hot AND-OR select of the granted input's fields.
  always_comb begin
    sel_cmd     = '0;
    sel_dst     = '0;
    sel_src     = '0;
    sel_payload = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel_cmd     = sel_cmd     | ({CW{grant[i]}} & umi_in_cmd[i*CW +: CW]);
      sel_dst     = sel_dst     | ({AW{grant[i]}} & umi_in_dst_addr[i*AW +: AW]);
      sel_src     = sel_src     | ({AW{grant[i]}} & umi_in_src_addr[i*AW +: AW]);
      sel_payload = sel_payload | ({UW{grant[i]}} & umi_in_payload[i*UW +: UW]);
    end
  end

  // Output valid: set on capture, cleared when drained with nothing to refill.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      umi_out_valid <= 1'b0;
    end else if (load) begin
      umi_out_valid <= |grant;
    end
  end

  // Output data registers, deliberately not reset; qualified by umi_out_valid.
  always_ff @(posedge clk) begin
    if (load && (|grant)) begin
      umi_out_cmd      <= sel_cmd;
      umi_out_dst_addr <= sel_dst;
      umi_out_src_addr <= sel_src;
      umi_out_payload  <= sel_payload;
    end
  end

endmodule : umi_mux

// File: tb/tb_umi_mux.sv
// Randomized self-checking bench for umi_mux with a cycle-level reference model.
module tb_umi_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned CW = 32;
  localparam int unsigned UW = 256;

  logic            clk;
  logic            nreset;
  logic [N-1:0]    umi_in_valid;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dst_addr;
  logic [N*AW-1:0] umi_in_src_addr;
  logic [N*UW-1:0] umi_in_payload;
  logic [N-1:0]    umi_in_ready;
  logic            umi_out_valid;
  logic [CW-1:0]   umi_out_cmd;
  logic [AW-1:0]   umi_out_dst_addr;
  logic [AW-1:0]   umi_out_src_addr;
  logic [UW-1:0]   umi_out_payload;
  logic            umi_out_ready;

  umi_mux #(
    .N (N), .AW (AW), .CW (CW), .UW (UW), .TARGET ("DEFAULT")
  ) dut (
    .clk              (clk),
    .nreset           (nreset),
    .umi_in_valid     (umi_in_valid),
    .umi_in_cmd       (umi_in_cmd),
    .umi_in_dst_addr  (umi_in_dst_addr),
    .umi_in_src_addr  (umi_in_src_addr),
    .umi_in_payload   (umi_in_payload),
    .umi_in_ready     (umi_in_ready),
    .umi_out_valid    (umi_out_valid),
    .umi_out_cmd      (umi_out_cmd),
    .umi_out_dst_addr (umi_out_dst_addr),
    .umi_out_src_addr (umi_out_src_addr),
    .umi_out_payload  (umi_out_payload),
    .umi_out_ready    (umi_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: rotating priority and the one-deep output slot.
  int            mptr;
  bit            mv;
  logic [CW-1:0] mcmd;
  logic [AW-1:0] mdst;
  logic [AW-1:0] msrc;
  logic [UW-1:0] mpay;

  bit            ovr_en;
  logic [CW-1:0] ovr_cmd;
  logic [N-1:0]  last_ready;
  bit            sb_en;
  logic [CW-1:0] sb_q[$];
  int            sb_sent;
  int            sb_seen;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // First valid input at or after p, wrapping modulo N; -1 if none.
  function automatic int mgrant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v, input bit rdy);
    logic [31:0] r;
    int g;
    bit ld;
    logic [N-1:0] er;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      r = $urandom();
      umi_in_cmd[i*CW +: CW] = ovr_en ? ovr_cmd : {r[31:4], 4'(i)};
      umi_in_dst_addr[i*AW +: AW] = {$urandom(), $urandom()};
      umi_in_src_addr[i*AW +: AW] = {$urandom(), $urandom()};
      for (int w = 0; w < UW / 32; w++) umi_in_payload[i*UW + w*32 +: 32] = $urandom();
    end
    umi_in_valid  = v;
    umi_out_ready = rdy;
    #1;
    g  = mgrant(v, mptr);
    ld = !mv || rdy;
    er = (ld && g >= 0) ? N'(1 << g) : '0;
    last_ready = umi_in_ready;
    chk("in_ready", umi_in_ready, er);
    if (sb_en) begin
      if (umi_out_valid && umi_out_ready) begin
        sb_seen++;
        if (sb_q.size() == 0) chk("sb_extra", umi_out_cmd, '1);
        else chk("sb_cmd", umi_out_cmd, sb_q.pop_front());
      end
      if (v[1]) begin
        sb_q.push_back(umi_in_cmd[1*CW +: CW]);
        sb_sent++;
      end
    end
    if (ld) begin
      if (g >= 0) begin
        mv   = 1'b1;
        mcmd = umi_in_cmd[g*CW +: CW];
        mdst = umi_in_dst_addr[g*AW +: AW];
        msrc = umi_in_src_addr[g*AW +: AW];
        mpay = umi_in_payload[g*UW +: UW];
        mptr = (g + 1) % N;
      end else begin
        mv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", umi_out_valid, mv);
    chk("ptr", dut.u_arb.ptr, mptr);
    if (mv) begin
      chk("out_cmd", umi_out_cmd, mcmd);
      chk("out_dst", umi_out_dst_addr, mdst);
      chk("out_src", umi_out_src_addr, msrc);
      chk("out_payload", umi_out_payload, mpay);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    umi_in_valid = '1;
    nreset = 1'b0;
    #1;
    mv   = 1'b0;
    mptr = 0;
    chk("rst_valid", umi_out_valid, 1'b0);
    chk("rst_ready", umi_in_ready, '0);
    chk("rst_ptr", dut.u_arb.ptr, 0);
    @(negedge clk);
    nreset = 1'b1;
    umi_in_valid = '0;
  endtask

  initial begin
    nreset          = 1'b0;
    umi_in_valid    = '1;
    umi_in_cmd      = '0;
    umi_in_dst_addr = '0;
    umi_in_src_addr = '0;
    umi_in_payload  = '0;
    umi_out_ready   = 1'b1;
    ovr_en  = 1'b0;
    ovr_cmd = '0;
    sb_en   = 1'b0;
    sb_sent = 0;
    sb_seen = 0;
    mptr    = 0;
    mv      = 1'b0;
    mcmd = '0; mdst = '0; msrc = '0; mpay = '0;

    // Reset state
    #12;
    chk("init_valid", umi_out_valid, 1'b0);
    chk("init_ready", umi_in_ready, '0);
    @(negedge clk);
    nreset = 1'b1;
    umi_in_valid = '0;

    // Single input 2 with fixed command
    ovr_en  = 1'b1;
    ovr_cmd = 32'h11;
    step(4'b0100, 1'b1);
    chk("single_ready", last_ready, 4'b0100);
    chk("single_cmd", umi_out_cmd, 32'h11);
    ovr_en = 1'b0;
    step(4'b0000, 1'b1);

    // Fairness: all valid from ptr=0 gives 0,1,2,3,0,1
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(4'b1111, 1'b1);
      chk("fair_src", umi_out_cmd[3:0], 4'(k % N));
    end

    // Stall for five cycles, then drain and refill
    step(4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(4'($urandom_range(0, 15)), 1'b0);
      chk("stall_ready", last_ready, '0);
    end
    step(4'b1111, 1'b1);
    chk("stall_refill", umi_out_valid, 1'b1);

    // Wrap: ptr=3 with inputs 0 and 1 valid picks 0, then ptr=1
    do_reset();
    step(4'b0100, 1'b1);
    chk("wrap_ptr3", dut.u_arb.ptr, 3);
    step(4'b0011, 1'b1);
    chk("wrap_src", umi_out_cmd[3:0], 4'd0);
    chk("wrap_ptr1", dut.u_arb.ptr, 1);
    step(4'b0000, 1'b1);

    // Reset mid-stream with a held beat, then input 0 wins
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);
    do_reset();
    step(4'b1111, 1'b1);
    chk("post_rst_src", umi_out_cmd[3:0], 4'd0);
    step(4'b0000, 1'b1);
    chk("post_rst_drain", umi_out_valid, 1'b0);

    // Sparse pulses on input 1: every beat out exactly once
    sb_en = 1'b1;
    for (int k = 0; k < 20; k++) step((k % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    sb_en = 1'b0;
    chk("sparse_count", 32'(sb_seen), 32'(sb_sent));
    chk("sparse_left", 32'(sb_q.size()), 32'd0);

    // Random traffic and backpressure
    for (int k = 0; k < 400; k++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      if (k == 200) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_umi_mux
